edge_scan_ctrl: RTL

Sequencer for one chain of EDGE scan cells and their shadow latches. Takes a parallel pattern and a mode from a host. Shifts the pattern into the chain, optionally runs a functional capture, pulses the shadow-latch enable, then shifts the captured chain contents back out into a parallel result register. It sits between the test/config host and the chain's TE/TI/en pins and the chain tail TQ.

---
 rtl/edge_scan_pkg.sv | 17 +
 rtl/edge_scan_shreg.sv | 57 +++++
 rtl/edge_scan_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/edge_scan_pkg.sv
// Shared types for the EDGE scan-chain sequencer.
// Holds the FSM state encoding and the run-mode constants used by the
// controller and by anything that decodes its debug state output.
package edge_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_LATCH   = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_TEST = 1'b1;

endpackage

// File: rtl/edge_scan_shreg.sv
// Data registers for one scan chain.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_pat  : parallel load of the pattern register
//   i_shift        : shift pattern towards bit 0, zero-filling the top
//   i_clr          : clear the pattern register (abort)
//   o_ser          : bit 0 of the pattern register (drives the chain head)
//   i_wr, i_idx,   : write one result bit at index i_idx from i_ser
//   i_ser
//   o_res          : parallel result register
module edge_scan_shreg #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic          i_clr,
  input  logic [N-1:0]  i_pat,
  output logic          o_ser,
  input  logic          i_wr,
  input  logic [IW-1:0] i_idx,
  input  logic          i_ser,
  output logic [N-1:0]  o_res
);

  logic [N-1:0] r_pat;
  logic [N-1:0] r_res;

  // Zero-fill means the serial output is already 0 once the last pattern
  // bit has left, so the head input rests low through capture and unload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat <= '0;
    end else if (i_load) begin
      r_pat <= i_pat;
    end else if (i_clr) begin
      r_pat <= '0;
    end else if (i_shift) begin
      r_pat <= {1'b0, r_pat[N-1:1]};
    end
  end

  // Indexed write rather than a shift: an aborted unload must leave the
  // bits it has not reached untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res <= '0;
    end else if (i_wr) begin
      r_res[i_idx] <= i_ser;
    end
  end

  assign o_ser = r_pat[0];
  assign o_res = r_res;

endmodule

// File: rtl/edge_scan_ctrl.sv
// Sequencer for one EDGE scan chain plus shadow latches.
// Shifts a pattern in, optionally captures, pulses the shadow enable, and
// in TEST mode unloads the chain into a parallel result.
//   CP, RN      : clock, asynchronous active-low reset
//   start, mode : run request (sampled in IDLE) and run type
//   abort       : synchronous cancel of a run in progress
//   pattern_in  : pattern, bit 0 shifted first, sampled with start
//   scan_so     : chain tail TQ
//   scan_te, scan_ti, shadow_en : chain TE, head TI, shadow latch enable
//   busy, done  : run in progress / one-cycle normal completion pulse
//   result      : unloaded chain contents
//   dbg_state   : current FSM state (edge_scan_pkg::state_t encoding)
// Handshake: start is accepted only on an edge where the FSM is IDLE and
// abort is low; busy then rises and stays high until the edge that either
// pulses done (normal end) or returns to IDLE on abort/reset (no done).
module edge_scan_ctrl
  import edge_scan_pkg::*;
#(
  parameter int CHAIN_LEN      = 32,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CP,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic                 scan_so,
  output logic                 scan_te,
  output logic                 scan_ti,
  output logic                 shadow_en,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAP = CW'(CAPTURE_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic          r_te;
  logic          r_shadow;
  logic          r_busy;
  logic          r_done;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic          w_load;
  logic          w_shift;
  logic          w_clr;
  logic          w_wr;
  logic          w_nxt_done;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    w_wr        = 1'b0;
    w_nxt_done  = 1'b0;
    if (r_state != ST_IDLE && abort) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_load      = 1'b1;
            w_nxt_state = ST_SHIFT;
            w_nxt_cnt   = '0;
          end
        end
        ST_SHIFT: begin
          w_shift = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_nxt_cnt   = '0;
            w_nxt_state = (r_mode == MODE_TEST) ? ST_CAPTURE : ST_LATCH;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (r_cnt == LAST_CAP) begin
            w_nxt_cnt   = '0;
            w_nxt_state = ST_LATCH;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          w_nxt_cnt = '0;
          if (r_mode == MODE_TEST) begin
            w_nxt_state = ST_UNLOAD;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_done  = 1'b1;
          end
        end
        ST_UNLOAD: begin
          w_wr = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so every pin
  // changes only after a CP rising edge and TE/shadow_en can never overlap.
  always_ff @(posedge CP or negedge RN) begin
    if (!RN) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mode   <= MODE_LOAD;
      r_te     <= 1'b0;
      r_shadow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      if (w_load) r_mode <= mode;
      r_te     <= (w_nxt_state == ST_SHIFT) || (w_nxt_state == ST_UNLOAD);
      r_shadow <= (w_nxt_state == ST_LATCH);
      r_busy   <= (w_nxt_state != ST_IDLE);
      r_done   <= w_nxt_done;
    end
  end

  edge_scan_shreg #(.N(CHAIN_LEN), .IW(CW)) u_shreg (
    .i_clk   (CP),
    .i_rst_n (RN),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_pat   (pattern_in),
    .o_ser   (scan_ti),
    .i_wr    (w_wr),
    .i_idx   (r_cnt),
    .i_ser   (scan_so),
    .o_res   (result)
  );

  assign scan_te   = r_te;
  assign shadow_en = r_shadow;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
